rst_seq: RTL and testbench

Parametrised reset sequencer. Synchronises an asynchronous active-high reset to `clk_i` through a configurable-depth synchroniser. After deassertion it enforces a minimum hold time, then releases `N_CH` active-low reset outputs one by one at a fixed spacing, and flags completion. It sits at the top of each clock domain and drives the per-subsystem resets for, e.g., the PLL-dependent logic, the LED output engines and the host interface. It also accepts a synchronous soft-reset request that replays the full sequence.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_sync_hi.sv | 24 ++
 rtl/rst_seq.sv | 108 ++++++++++
 tb/tb_rst_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  // Sequencer phases: hold all resets, release one by one, then idle released.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } rst_seq_state_t;

  // Counter width large enough to hold the longer of the two intervals.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int longest;
    longest = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
    return $clog2(longest + 1);
  endfunction

  // Channel index width; a single channel still needs one bit.
  function automatic int idx_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/rst_sync_hi.sv
// Reset synchroniser: asynchronous assertion, release synchronised to clk_i.
// sync_o goes high SYNC_STAGES edges after rst_i is sampled low.
module rst_sync_hi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift a constant one through the chain; rst_i clears every stage at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_o = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronises rst_i, holds all channel resets for
// HOLD_CYCLES, then releases the active-low channels in ascending order
// every STEP_CYCLES and flags completion. soft_rst_i replays the sequence.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int N_CH        = 4,
  parameter int STEP_CYCLES = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            soft_rst_i,
  output logic [N_CH-1:0] rst_n_o,
  output logic            done_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IDX_W = idx_width(N_CH);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CH0_MASK  = N_CH'(1'b1);

  rst_seq_state_t  state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nx_s;
  logic [N_CH-1:0]  rst_n_r;
  logic             done_r;
  logic             sync_ok_s;

  rst_sync_hi #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sync_o(sync_ok_s)
  );

  // Channel that the next step will release.
  assign idx_nx_s = idx_r + IDX_W'(1'b1);

  // Sequencer FSM with its counter and registered outputs. rst_i clears
  // asynchronously; soft_rst_i takes priority over normal sequencing and
  // keeps the hold count at zero for as long as it stays high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= HOLD;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      rst_n_r <= {N_CH{1'b0}};
      done_r  <= 1'b0;
    end else if (soft_rst_i) begin
      state_r <= HOLD;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      rst_n_r <= {N_CH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        HOLD: begin
          if (!sync_ok_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_r == HOLD_LAST) begin
            rst_n_r <= rst_n_r | CH0_MASK;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            state_r <= (N_CH == 1) ? DONE : RELEASE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        RELEASE: begin
          if (cnt_r == STEP_LAST) begin
            rst_n_r <= rst_n_r | (CH0_MASK << idx_nx_s);
            idx_r   <= idx_nx_s;
            cnt_r   <= {CNT_W{1'b0}};
            if (idx_nx_s == IDX_LAST) begin
              state_r <= DONE;
            end else begin
              state_r <= RELEASE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: restart the whole sequence safely.
          state_r <= HOLD;
          cnt_r   <= {CNT_W{1'b0}};
          idx_r   <= {IDX_W{1'b0}};
          rst_n_r <= {N_CH{1'b0}};
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o = rst_n_r;
  assign done_o  = done_r;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: a default instance and a minimal one
// (S=3, H=1, N=1, STEP=1) share the stimulus. Expected outputs come from the
// release-edge formulas: channel k is free from edge t0 + k*STEP, where t0 is
// the later of (edge0 + S + H) and (F + H - 1) for the last soft release F.
module tb_rst_seq;

  localparam int AS = 2, AH = 16, AN = 4, ASTEP = 8;
  localparam int BS = 3, BH = 1,  BN = 1, BSTEP = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          soft_rst_i;
  logic [AN-1:0] a_rst_n;
  logic          a_done;
  logic [BN-1:0] b_rst_n;
  logic          b_done;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference state (absolute edge numbers).
  int  edge_no = 0;
  int  e1      = 0;   // first edge sampling rst_i low after the last reset
  int  f_edge  = 0;   // first low edge after a soft request, 0 if none
  bit  in_rst  = 1'b1;
  bit  soft_hi = 1'b0;

  rst_seq #(.SYNC_STAGES(AS), .HOLD_CYCLES(AH), .N_CH(AN), .STEP_CYCLES(ASTEP)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .soft_rst_i(soft_rst_i), .rst_n_o(a_rst_n), .done_o(a_done));

  rst_seq #(.SYNC_STAGES(BS), .HOLD_CYCLES(BH), .N_CH(BN), .STEP_CYCLES(BSTEP)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .soft_rst_i(soft_rst_i), .rst_n_o(b_rst_n), .done_o(b_done));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  // Edge at which channel 0 is released, or -1 while everything is held.
  function automatic int first_release(input int s, input int h);
    int t0;
    if (in_rst || soft_hi || e1 == 0) return -1;
    t0 = e1 - 1 + s + h;
    if (f_edge != 0 && (f_edge + h - 1) > t0) t0 = f_edge + h - 1;
    return t0;
  endfunction

  function automatic logic [31:0] exp_rst_n(input int s, input int h, input int n, input int step);
    logic [31:0] v;
    int t0;
    v  = 32'd0;
    t0 = first_release(s, h);
    if (t0 >= 0) begin
      for (int k = 0; k < n; k++) v[k] = (edge_no >= t0 + k * step);
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_done(input int s, input int h, input int n, input int step);
    int t0;
    t0 = first_release(s, h);
    return (t0 >= 0 && edge_no >= t0 + (n - 1) * step + 1) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_all(input string when);
    check({when, ":a_rst_n"}, {{(32-AN){1'b0}}, a_rst_n}, exp_rst_n(AS, AH, AN, ASTEP));
    check({when, ":a_done"},  {31'd0, a_done},            exp_done(AS, AH, AN, ASTEP));
    check({when, ":b_rst_n"}, {{(32-BN){1'b0}}, b_rst_n}, exp_rst_n(BS, BH, BN, BSTEP));
    check({when, ":b_done"},  {31'd0, b_done},            exp_done(BS, BH, BN, BSTEP));
  endtask

  // Any rising rst_i, even a short glitch, restarts the sequence.
  always @(posedge rst_i) in_rst = 1'b1;

  // Reference model update on each edge, then output comparison 1 ns later.
  always @(posedge clk_i) begin
    edge_no++;
    if (rst_i) begin
      in_rst  = 1'b1;
      soft_hi = 1'b0;
      f_edge  = 0;
    end else begin
      if (in_rst) begin
        in_rst  = 1'b0;
        e1      = edge_no;
        f_edge  = 0;
        soft_hi = 1'b0;
      end
      if (soft_rst_i) begin
        soft_hi = 1'b1;
      end else if (soft_hi) begin
        soft_hi = 1'b0;
        f_edge  = edge_no;
      end
    end
    #1;
    check_all("edge");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Short rst_i pulse between edges; outputs must clear without a clock.
  task automatic glitch();
    rst_i = 1'b1;
    #1;
    check_all("glitch");
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    soft_rst_i = 1'b0;
    cycles(3);
    rst_i = 1'b0;
    cycles(50);                 // full default sequence, done at edge 43

    rst_i = 1'b1; cycles(2); rst_i = 1'b0;
    cycles(29);                 // just after edge 29, mid RELEASE
    glitch();
    cycles(50);

    soft_rst_i = 1'b1; cycles(5); soft_rst_i = 1'b0;   // from DONE
    cycles(45);

    rst_i = 1'b1; cycles(1); rst_i = 1'b0;
    cycles(12);                 // HOLD with cnt = 10
    soft_rst_i = 1'b1; cycles(1); soft_rst_i = 1'b0;
    cycles(45);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: cycles($urandom_range(1, 45));
        1: begin soft_rst_i = 1'b1; cycles($urandom_range(1, 6)); soft_rst_i = 1'b0; end
        2: begin rst_i = 1'b1; cycles($urandom_range(1, 3)); rst_i = 1'b0; end
        3: glitch();
        default: begin
          rst_i = 1'b1; soft_rst_i = 1'b1; cycles(1);
          rst_i = 1'b0; cycles($urandom_range(0, 4)); soft_rst_i = 1'b0;
        end
      endcase
      cycles(1);
    end
    cycles(45);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
